// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: shared FSM state encoding, default widths and saturation limit for the TX packet scheduler.
package tx_sched_pkg;
   localparam int CNT_W_DEF = 28;
   localparam int SEG_W_DEF = 16;
   localparam int RED_W_DEF = 8;
   localparam int SEQ_W_DEF = 32;
   localparam logic [15:0] OVR_MAX = 16'hFFFF;
   typedef enum logic [2:0] {IDLE, ARMED, START, WAIT_DONE, ADVANCE} state_e;
endpackage

// File: rtl/tx_interval_timer.sv
// tx_interval_timer: free-running 0..max_count counter while run is high; tick marks each wrap.
module tx_interval_timer
   import tx_sched_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [CNT_W-1:0] max_count,
   output logic             tick
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // >= keeps the counter bounded when max_count shrinks while running
   assign tick  = run && (cnt_q >= max_count);
   assign cnt_d = (!run || tick) ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/tx_packet_scheduler.sv
// tx_packet_scheduler: paces tx_start pulses per interval tick and tags frames with seq/segment/copy indices.
// Optional TX_SCHED_STATS_EN adds frames_sent and stats_clr.
module tx_packet_scheduler
   import tx_sched_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int SEG_W = SEG_W_DEF,
   parameter int RED_W = RED_W_DEF,
   parameter int SEQ_W = SEQ_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [CNT_W-1:0] max_count,
   input  logic [SEG_W-1:0] segment_num_max,
   input  logic [RED_W-1:0] redundancy,
   input  logic             tx_busy,
   input  logic             tx_done,
`ifdef TX_SCHED_STATS_EN
   input  logic             stats_clr,
   output logic [31:0]      frames_sent,
`endif
   output logic             tx_start,
   output logic [SEQ_W-1:0] seq_num,
   output logic [SEG_W-1:0] segment_idx,
   output logic [RED_W-1:0] copy_idx,
   output logic             sched_active,
   output logic [15:0]      overrun_cnt
);
   state_e state_q, state_d;
   logic [CNT_W-1:0] cfg_max_q, cfg_max_d;
   logic [SEG_W-1:0] cfg_seg_q, cfg_seg_d, seg_q, seg_d;
   logic [RED_W-1:0] cfg_red_q, cfg_red_d, copy_q, copy_d;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic [15:0]      ovr_q, ovr_d;
   logic             pending_q, pending_d;
   logic             tick, consume, to_idle, adv, copy_last, seg_last, latch, ovr_inc;

   tx_interval_timer #(.CNT_W(CNT_W)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (state_q != IDLE),
      .max_count (cfg_max_q),
      .tick      (tick)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (enable) state_d = ARMED;
         ARMED:     if (!enable) state_d = IDLE;
                    else if (pending_q && !tx_busy) state_d = START;
         START:     state_d = WAIT_DONE;
         WAIT_DONE: if (tx_done) state_d = ADVANCE;
         ADVANCE:   state_d = enable ? ARMED : IDLE;
         default:   state_d = IDLE;
      endcase
   end

   assign consume   = (state_q == ARMED) && (state_d == START);
   assign to_idle   = (state_d == IDLE);
   assign adv       = (state_q == ADVANCE);
   assign copy_last = (copy_q == cfg_red_q - 1'b1);
   assign seg_last  = (seg_q == cfg_seg_q - 1'b1);
   // config is only taken at a sequence boundary so a burst never mixes settings
   assign latch     = ((state_q == IDLE) && (state_d == ARMED)) || (adv && copy_last && seg_last);
   assign ovr_inc   = tick && pending_q && !consume && (ovr_q != OVR_MAX);

   always_comb begin
      cfg_max_d = latch ? max_count : cfg_max_q;
      cfg_seg_d = latch ? ((segment_num_max == '0) ? SEG_W'(1) : segment_num_max) : cfg_seg_q;
      cfg_red_d = latch ? ((redundancy == '0) ? RED_W'(1) : redundancy) : cfg_red_q;
      copy_d    = to_idle ? '0 : adv ? (copy_last ? '0 : copy_q + 1'b1) : copy_q;
      seg_d     = to_idle ? '0 : (adv && copy_last) ? (seg_last ? '0 : seg_q + 1'b1) : seg_q;
      seq_d     = (adv && copy_last && seg_last) ? seq_q + 1'b1 : seq_q;
      pending_d = to_idle ? 1'b0 : tick ? 1'b1 : consume ? 1'b0 : pending_q;
   end

`ifdef TX_SCHED_STATS_EN
   logic [31:0] frames_q, frames_d;
   assign ovr_d       = stats_clr ? '0 : ovr_inc ? ovr_q + 1'b1 : ovr_q;
   assign frames_d    = stats_clr ? '0 : (state_q == START) ? frames_q + 1'b1 : frames_q;
   assign frames_sent = frames_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frames_q <= '0;
      else        frames_q <= frames_d;
   end
`else
   assign ovr_d = ovr_inc ? ovr_q + 1'b1 : ovr_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cfg_max_q <= '0;
         cfg_seg_q <= SEG_W'(1);
         cfg_red_q <= RED_W'(1);
         seq_q     <= '0;
         seg_q     <= '0;
         copy_q    <= '0;
         ovr_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_max_q <= cfg_max_d;
         cfg_seg_q <= cfg_seg_d;
         cfg_red_q <= cfg_red_d;
         seq_q     <= seq_d;
         seg_q     <= seg_d;
         copy_q    <= copy_d;
         ovr_q     <= ovr_d;
         pending_q <= pending_d;
      end
   end

   assign tx_start     = (state_q == START);
   assign seq_num      = seq_q;
   assign segment_idx  = seg_q;
   assign copy_idx     = copy_q;
   assign sched_active = (state_q != IDLE);
   assign overrun_cnt  = ovr_q;
endmodule

// File: tb/tb_tx_packet_scheduler.sv
// tb_tx_packet_scheduler: directed checks of pacing, index order, overrun counting, enable drop and reset.
module tb_tx_packet_scheduler;
   logic        clk = 1'b0;
   logic        rst_n, enable, tx_busy, stats_clr;
   logic        tx_done = 1'b0;
   logic [27:0] max_count;
   logic [15:0] segment_num_max, overrun_cnt, segment_idx;
   logic [7:0]  redundancy, copy_idx;
   logic [31:0] seq_num;
   logic        tx_start, sched_active;
`ifdef TX_SCHED_STATS_EN
   logic [31:0] frames_sent;
`endif
   int          checks = 0, errors = 0;
   int          cyc = 0, nst = 0, base = 0, dcnt = 0, done_dly = 1, overlap = 0;
   int          cyc_l [64];
   logic [55:0] tup_l [64];
   logic [15:0] ovr_l [64];
   logic [55:0] e2 [7];
   logic [55:0] e4 [10];

   tx_packet_scheduler dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .enable          (enable),
      .max_count       (max_count),
      .segment_num_max (segment_num_max),
      .redundancy      (redundancy),
      .tx_busy         (tx_busy),
      .tx_done         (tx_done),
`ifdef TX_SCHED_STATS_EN
      .stats_clr       (stats_clr),
      .frames_sent     (frames_sent),
`endif
      .tx_start        (tx_start),
      .seq_num         (seq_num),
      .segment_idx     (segment_idx),
      .copy_idx        (copy_idx),
      .sched_active    (sched_active),
      .overrun_cnt     (overrun_cnt)
   );

   always #5 clk = ~clk;

   // frame responder and start logger; tx_done arrives done_dly cycles after tx_start
   always @(negedge clk) begin
      cyc++;
      tx_done = 1'b0;
      if (!rst_n) dcnt = 0;
      else begin
         if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) tx_done = 1'b1;
         end
         if (tx_start) begin
            if (dcnt > 0) overlap++;
            if (nst < 64) begin
               cyc_l[nst] = cyc;
               tup_l[nst] = {seq_num, segment_idx, copy_idx};
               ovr_l[nst] = overrun_cnt;
            end
            nst++;
            dcnt = done_dly;
         end
      end
   end

   function automatic logic [55:0] mk(input int s, input int g, input int c);
      return {s[31:0], g[15:0], c[7:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_starts(input string tag, input int n, input int budget);
      int k = 0;
      while (nst - base < n && k < budget) begin
         step();
         k++;
      end
      chk(tag, 64'(nst - base), 64'(n));
   endtask

   task automatic do_reset();
      enable = 1'b0;
      rst_n  = 1'b0;
      step();
      step();
      rst_n  = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; tx_busy = 1'b0; stats_clr = 1'b0;
      max_count = 28'd3; segment_num_max = 16'd1; redundancy = 8'd1;
      e2 = '{mk(0,0,0), mk(0,0,1), mk(0,0,2), mk(0,1,0), mk(0,1,1), mk(0,1,2), mk(1,0,0)};
      e4 = '{mk(0,0,0), mk(0,1,0), mk(0,2,0), mk(0,3,0), mk(1,0,0),
             mk(1,0,1), mk(1,0,2), mk(1,0,3), mk(1,0,4), mk(1,1,0)};
      step();
      step();
      chk("rst_start", 64'(tx_start), 0);
      chk("rst_seq", 64'(seq_num), 0);
      chk("rst_idx", 64'({segment_idx, copy_idx}), 0);
      chk("rst_active", 64'(sched_active), 0);
      chk("rst_ovr", 64'(overrun_cnt), 0);

      rst_n = 1'b1; enable = 1'b1; base = nst;
      step();
      chk("t1_active", 64'(sched_active), 1);
      wait_starts("t1_tmo", 5, 100);
      for (int i = 1; i < 5; i++) begin
         chk("t1_gap", 64'(cyc_l[base+i] - cyc_l[base+i-1]), 4);
         chk("t1_tup", 64'(tup_l[base+i]), 64'(mk(i,0,0)));
         chk("t1_ovr", 64'(ovr_l[base+i]), 0);
      end
      enable = 1'b0;
      for (int k = 0; k < 20 && sched_active; k++) step();
      chk("t1_idle", 64'(sched_active), 0);
      chk("t1_idx_clr", 64'({segment_idx, copy_idx}), 0);

      do_reset();
      max_count = 28'd9; segment_num_max = 16'd2; redundancy = 8'd3;
      enable = 1'b1; base = nst;
      wait_starts("t2_tmo", 7, 200);
      for (int i = 0; i < 7; i++) chk("t2_tup", 64'(tup_l[base+i]), 64'(e2[i]));

      do_reset();
      max_count = 28'd3; segment_num_max = 16'd1; redundancy = 8'd1; done_dly = 17;
      enable = 1'b1; base = nst;
      wait_starts("t3_tmo", 5, 300);
      for (int i = 0; i < 5; i++) chk("t3_ovr", 64'(ovr_l[base+i]), 64'(4 * i));
      for (int i = 1; i < 5; i++) chk("t3_gap", 64'(cyc_l[base+i] - cyc_l[base+i-1]), 20);
      chk("t3_overlap", 64'(overlap), 0);

      do_reset();
      max_count = 28'd9; segment_num_max = 16'd4; redundancy = 8'd1; done_dly = 1;
      enable = 1'b1; base = nst;
      wait_starts("t4_first", 1, 100);
      redundancy = 8'd5;
      wait_starts("t4_tmo", 10, 400);
      for (int i = 0; i < 10; i++) chk("t4_tup", 64'(tup_l[base+i]), 64'(e4[i]));

      do_reset();
      max_count = 28'd3; segment_num_max = 16'd1; redundancy = 8'd2; done_dly = 5;
      enable = 1'b1; base = nst;
      wait_starts("t5_tmo", 2, 100);
      enable = 1'b0;
      for (int k = 0; k < 20 && !tx_done; k++) step();
      chk("t5_done", 64'(tx_done), 1);
      chk("t5_adv_active", 64'(sched_active), 1);
      step();
      chk("t5_idle", 64'(sched_active), 0);
      chk("t5_seq_held", 64'(seq_num), 1);
      chk("t5_idx_clr", 64'({segment_idx, copy_idx}), 0);
      repeat (30) step();
      chk("t5_no_start", 64'(nst - base), 2);

      do_reset();
      max_count = 28'd3; segment_num_max = 16'd0; redundancy = 8'd0; done_dly = 50;
      enable = 1'b1; base = nst;
      wait_starts("t6_tmo", 1, 100);
      repeat (20) step();
      chk("t6_ovr_pre", 64'(overrun_cnt), 4);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_start", 64'(tx_start), 0);
      chk("t6_rst_seq", 64'(seq_num), 0);
      chk("t6_rst_idx", 64'({segment_idx, copy_idx}), 0);
      chk("t6_rst_active", 64'(sched_active), 0);
      chk("t6_rst_ovr", 64'(overrun_cnt), 0);
      done_dly = 1; tx_busy = 1'b1;
      step();
      rst_n = 1'b1; base = nst;
      repeat (12) step();
      chk("t6_busy_hold", 64'(nst - base), 0);
      tx_busy = 1'b0;
      wait_starts("t6_restart", 3, 100);
      for (int i = 0; i < 3; i++) chk("t6_tup", 64'(tup_l[base+i]), 64'(mk(i,0,0)));
      chk("overlap", 64'(overlap), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
